// File: rtl/capture_history.sv
// Snapshot history: captures i_val into a newest-first history on synchronised trigger edges.
// Optional CAPTURE_HISTORY_DEBOUNCE_EN adds a settle counter before a trigger level is accepted.
module capture_history #(
    parameter int p_width     = 6,
    parameter int p_depth     = 3,
    parameter int p_edge_mode = 0,
    parameter int p_debounce  = 1_000_000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [p_width-1:0] i_val,
    input  logic               i_trig,
    input  logic               i_clr,
    input  logic               i_hold,
    output logic [p_width-1:0] o_hist [p_depth],
    output logic [p_depth-1:0] o_valid,
    output logic [$clog2(p_depth+1)-1:0] o_count,
    output logic               o_full,
    output logic               o_cap
);
    localparam int CW = $clog2(p_depth + 1);

    if (p_depth < 1 || p_debounce < 1) begin : g_bad_param
        $error("capture_history: p_depth and p_debounce must be >= 1");
    end

`ifdef CAPTURE_HISTORY_DEBOUNCE_EN
    localparam int DW = $clog2(p_debounce + 1);
    typedef enum logic [1:0] {S_ARM, S_RUN, S_SETTLE} state_t;
    logic [DW-1:0] deb_q, deb_d;
`else
    typedef enum logic [1:0] {S_ARM, S_RUN} state_t;
`endif

    state_t state_q, state_d;
    logic [1:0] arm_q, arm_d;
    logic s1_q, s1_d, s2_q, s2_d;
    logic prev_q, prev_d;
    logic edge_q, edge_d;
    logic cap_q, cap_d;
    logic [p_width-1:0] hist_q [p_depth];
    logic [p_width-1:0] hist_d [p_depth];
    logic [p_depth-1:0] valid_q, valid_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic edge_ok(input logic cur, input logic prv);
        case (p_edge_mode)
            1:       edge_ok = cur & ~prv;
            2:       edge_ok = ~cur & prv;
            default: edge_ok = cur ^ prv;
        endcase
    endfunction

    always_comb begin
        s1_d    = i_trig;
        s2_d    = s1_q;
        state_d = state_q;
        arm_d   = arm_q;
        prev_d  = prev_q;
        edge_d  = 1'b0;
        cap_d   = 1'b0;
        hist_d  = hist_q;
        valid_d = valid_q;
        count_d = count_q;
`ifdef CAPTURE_HISTORY_DEBOUNCE_EN
        deb_d   = deb_q;
`endif
        unique case (state_q)
            S_ARM: begin
                prev_d = s2_q;
                if (arm_q == 2'd2) state_d = S_RUN;
                else               arm_d   = arm_q + 2'd1;
            end
`ifdef CAPTURE_HISTORY_DEBOUNCE_EN
            S_RUN: begin
                if (s2_q != prev_q) begin
                    state_d = S_SETTLE;
                    deb_d   = DW'(p_debounce - 1);
                end
            end
            S_SETTLE: begin
                // prev_q is the last accepted stable level here
                if (s2_q == prev_q) begin
                    state_d = S_RUN;
                end else if (deb_q == '0) begin
                    prev_d  = s2_q;
                    edge_d  = edge_ok(s2_q, prev_q);
                    state_d = S_RUN;
                end else begin
                    deb_d = deb_q - DW'(1);
                end
            end
`else
            S_RUN: begin
                edge_d = edge_ok(s2_q, prev_q);
                prev_d = s2_q;
            end
`endif
            default: state_d = S_ARM;
        endcase

        if (i_clr) begin
            for (int i = 0; i < p_depth; i++) hist_d[i] = '0;
            valid_d = '0;
            count_d = '0;
        end else if (edge_q && !i_hold) begin
            cap_d      = 1'b1;
            hist_d[0]  = i_val;
            valid_d[0] = 1'b1;
            for (int i = 1; i < p_depth; i++) begin
                hist_d[i]  = hist_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
            if (count_q != CW'(p_depth)) count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_ARM;
            arm_q   <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
            cap_q   <= 1'b0;
            for (int i = 0; i < p_depth; i++) hist_q[i] <= '0;
            valid_q <= '0;
            count_q <= '0;
`ifdef CAPTURE_HISTORY_DEBOUNCE_EN
            deb_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prev_q  <= prev_d;
            edge_q  <= edge_d;
            cap_q   <= cap_d;
            hist_q  <= hist_d;
            valid_q <= valid_d;
            count_q <= count_d;
`ifdef CAPTURE_HISTORY_DEBOUNCE_EN
            deb_q   <= deb_d;
`endif
        end
    end

    assign o_hist  = hist_q;
    assign o_valid = valid_q;
    assign o_count = count_q;
    assign o_full  = (count_q == CW'(p_depth));
    assign o_cap   = cap_q;
endmodule
